// File: rtl/cpld_macro_pkg.sv
// Shared constants and helpers for the CPLD macrocell family.
package cpld_macro_pkg;

    localparam int MC_MODE_D    = 0;
    localparam int MC_MODE_T    = 1;
    localparam int MC_MODE_COMB = 2;
    localparam int MC_MAX_PT    = 16;

    // True when the product-term count and register mode describe a real macrocell.
    function automatic bit mc_params_legal(input int num_pt, input int reg_mode);
        return (num_pt >= 1) && (num_pt <= MC_MAX_PT) &&
               (reg_mode >= MC_MODE_D) && (reg_mode <= MC_MODE_COMB);
    endfunction

endpackage

// File: rtl/cpld_pt_sum.sv
// Product-term OR with optional output polarity inversion. Purely combinational.
// When SKIP_FIRST is set, PT[0] is reserved for another use (e.g. clock enable)
// and does not take part in the sum.
module cpld_pt_sum
    import cpld_macro_pkg::*;
#(
    parameter int NUM_PT     = 5,
    parameter int XOR_POL    = 0,
    parameter int SKIP_FIRST = 0
) (
    input  logic [NUM_PT-1:0] pt,
    output logic              d
);

    logic sum;

    // Select which product terms feed the OR; a single reserved term leaves an empty sum.
    generate
        if (SKIP_FIRST != 0 && NUM_PT == 1) begin : g_sum_empty
            assign sum = 1'b0;
        end else if (SKIP_FIRST != 0) begin : g_sum_skip
            assign sum = |pt[NUM_PT-1:1];
        end else begin : g_sum_all
            assign sum = |pt;
        end
    endgenerate

    assign d = sum ^ (XOR_POL != 0);

endmodule

// File: rtl/cpld_macrocell.sv
// CPLD macrocell: product-term sum, polarity, D/T register or combinational
// bypass, synchronous product-term clear/preset, pin output and array feedback.
module cpld_macrocell
    import cpld_macro_pkg::*;
#(
    parameter int NUM_PT   = 5,
    parameter int REG_MODE = 0,
    parameter int XOR_POL  = 0,
    parameter int INIT     = 0,
    parameter int PT_CE    = 0
) (
    input  logic              CK,
    input  logic              RN,
    input  logic [NUM_PT-1:0] PT,
    input  logic              CE,
    input  logic              PTCLR,
    input  logic              PTSET,
    input  logic              PTOE,
    output logic              Z0,
    output logic              OE,
    output logic              FB
);

    localparam logic INIT_BIT = (INIT != 0);

    // Reject impossible configurations while the design is being elaborated.
    generate
        if (!mc_params_legal(NUM_PT, REG_MODE)) begin : g_bad_param
            $error("cpld_macrocell: illegal parameters NUM_PT=%0d REG_MODE=%0d", NUM_PT, REG_MODE);
        end
    endgenerate

    logic d;

    cpld_pt_sum #(
        .NUM_PT     (NUM_PT),
        .XOR_POL    (XOR_POL),
        .SKIP_FIRST (PT_CE)
    ) u_pt_sum (
        .pt (PT),
        .d  (d)
    );

    assign OE = PTOE;

    generate
        if (REG_MODE == MC_MODE_COMB) begin : g_bypass
            // No state: the polarised sum goes straight to the pin and feedback.
            assign Z0 = d;
            assign FB = d;
        end else begin : g_register
            logic en;
            logic load_val;
            logic q_reg;
            logic q_next;

            assign en       = (PT_CE != 0) ? (CE & PT[0]) : CE;
            assign load_val = (REG_MODE == MC_MODE_T) ? (q_reg ^ d) : d;

            // Priority select: reset, clear, preset, enable; ternaries keep X on RN/PT visible.
            always_comb begin
                q_next = q_reg;
                q_next = !RN  ? INIT_BIT :
                         PTCLR ? 1'b0    :
                         PTSET ? 1'b1    :
                         en    ? load_val : q_reg;
            end

            // Macrocell register, all controls synchronous to CK.
            always_ff @(posedge CK) begin
                q_reg <= q_next;
            end

            assign Z0 = q_reg;
            assign FB = q_reg;
        end
    endgenerate

endmodule

// File: tb/tb_cpld_macrocell.sv
// Directed bench for cpld_macrocell. Six instances cover D, T (two INIT values),
// combinational bypass with inverted polarity, product-term clock enable and D with INIT=1.
module tb_cpld_macrocell;

    // Instance slots
    localparam int S_D   = 0;  // D, INIT=0
    localparam int S_T   = 1;  // T, INIT=0
    localparam int S_T1  = 2;  // T, INIT=1
    localparam int S_C   = 3;  // COMB, XOR_POL=1
    localparam int S_P   = 4;  // D, PT_CE=1
    localparam int S_D1  = 5;  // D, INIT=1

    logic       ck;
    logic [4:0] pt [6];
    logic [5:0] rn, ce, ptclr, ptset, ptoe;
    wire  [5:0] z0, oe, fb;

    int checks   = 0;
    int failures = 0;

    initial ck = 1'b0;
    always #5 ck = ~ck;

    cpld_macrocell #(.NUM_PT(5), .REG_MODE(0), .XOR_POL(0), .INIT(0), .PT_CE(0)) u_d (
        .CK(ck), .RN(rn[S_D]), .PT(pt[S_D]), .CE(ce[S_D]), .PTCLR(ptclr[S_D]),
        .PTSET(ptset[S_D]), .PTOE(ptoe[S_D]), .Z0(z0[S_D]), .OE(oe[S_D]), .FB(fb[S_D]));

    cpld_macrocell #(.NUM_PT(5), .REG_MODE(1), .XOR_POL(0), .INIT(0), .PT_CE(0)) u_t (
        .CK(ck), .RN(rn[S_T]), .PT(pt[S_T]), .CE(ce[S_T]), .PTCLR(ptclr[S_T]),
        .PTSET(ptset[S_T]), .PTOE(ptoe[S_T]), .Z0(z0[S_T]), .OE(oe[S_T]), .FB(fb[S_T]));

    cpld_macrocell #(.NUM_PT(5), .REG_MODE(1), .XOR_POL(0), .INIT(1), .PT_CE(0)) u_t1 (
        .CK(ck), .RN(rn[S_T1]), .PT(pt[S_T1]), .CE(ce[S_T1]), .PTCLR(ptclr[S_T1]),
        .PTSET(ptset[S_T1]), .PTOE(ptoe[S_T1]), .Z0(z0[S_T1]), .OE(oe[S_T1]), .FB(fb[S_T1]));

    cpld_macrocell #(.NUM_PT(5), .REG_MODE(2), .XOR_POL(1), .INIT(0), .PT_CE(0)) u_c (
        .CK(ck), .RN(rn[S_C]), .PT(pt[S_C]), .CE(ce[S_C]), .PTCLR(ptclr[S_C]),
        .PTSET(ptset[S_C]), .PTOE(ptoe[S_C]), .Z0(z0[S_C]), .OE(oe[S_C]), .FB(fb[S_C]));

    cpld_macrocell #(.NUM_PT(5), .REG_MODE(0), .XOR_POL(0), .INIT(0), .PT_CE(1)) u_p (
        .CK(ck), .RN(rn[S_P]), .PT(pt[S_P]), .CE(ce[S_P]), .PTCLR(ptclr[S_P]),
        .PTSET(ptset[S_P]), .PTOE(ptoe[S_P]), .Z0(z0[S_P]), .OE(oe[S_P]), .FB(fb[S_P]));

    cpld_macrocell #(.NUM_PT(5), .REG_MODE(0), .XOR_POL(0), .INIT(1), .PT_CE(0)) u_d1 (
        .CK(ck), .RN(rn[S_D1]), .PT(pt[S_D1]), .CE(ce[S_D1]), .PTCLR(ptclr[S_D1]),
        .PTSET(ptset[S_D1]), .PTOE(ptoe[S_D1]), .Z0(z0[S_D1]), .OE(oe[S_D1]), .FB(fb[S_D1]));

    // Single comparison point: counts, logs one line, flags mismatches.
    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: %b (t=%0t)", tag, obs, $time);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    // Pin output and feedback of one slot against the same expected value.
    task automatic check_q(input string tag, input int s, input logic exp);
        check_bit({tag, ".z0"}, z0[s], exp);
        check_bit({tag, ".fb"}, fb[s], exp);
    endtask

    initial begin
        rn = '0; ce = '0; ptclr = '0; ptset = '0; ptoe = '0;
        for (int i = 0; i < 6; i++) pt[i] = '0;

        // Reset state
        tick();
        tick();
        check_q("rst_d",  S_D,  1'b0);
        check_q("rst_t",  S_T,  1'b0);
        check_q("rst_t1", S_T1, 1'b1);
        check_q("rst_c",  S_C,  1'b1);
        check_q("rst_p",  S_P,  1'b0);
        check_q("rst_d1", S_D1, 1'b1);
        check_bit("rst_oe", oe[S_D], 1'b0);
        rn = '1;

        // 1: D mode
        pt[S_D] = 5'b00100; ce[S_D] = 1'b1;
        #1 check_q("d_latency", S_D, 1'b0);
        tick(); check_q("d_set", S_D, 1'b1);
        pt[S_D] = 5'b00000;
        tick(); check_q("d_clr", S_D, 1'b0);

        // 2: T mode toggling then hold
        pt[S_T] = 5'b00001; ce[S_T] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(); check_q($sformatf("t_tog%0d", i), S_T, (i % 2 == 0));
        end
        tick(); check_q("t_tog6", S_T, 1'b1);
        ce[S_T] = 1'b0;
        tick(); check_q("t_hold0", S_T, 1'b1);
        tick(); check_q("t_hold1", S_T, 1'b1);

        // 3: priority
        pt[S_D] = 5'b11111; ce[S_D] = 1'b1; ptset[S_D] = 1'b1; ptclr[S_D] = 1'b1;
        tick(); check_q("pri_clr_wins", S_D, 1'b0);
        ptclr[S_D] = 1'b0; ce[S_D] = 1'b0; pt[S_D] = 5'b00000;
        tick(); check_q("pri_set_no_ce", S_D, 1'b1);
        ptset[S_D] = 1'b0; ptclr[S_D] = 1'b1;
        tick(); check_q("pri_clr_no_ce", S_D, 1'b0);
        ptclr[S_D] = 1'b0; ptset[S_D] = 1'b1;
        tick(); check_q("pri_set_again", S_D, 1'b1);
        rn[S_D] = 1'b0;
        tick(); check_q("pri_rn_init0", S_D, 1'b0);
        rn[S_D] = 1'b1; ptset[S_D] = 1'b0;

        ptclr[S_D1] = 1'b1;
        tick(); check_q("pri_d1_clr", S_D1, 1'b0);
        ptclr[S_D1] = 1'b0; rn[S_D1] = 1'b0; ptset[S_D1] = 1'b1;
        tick(); check_q("pri_rn_init1_set", S_D1, 1'b1);
        ptset[S_D1] = 1'b0; ptclr[S_D1] = 1'b1;
        tick(); check_q("pri_rn_over_clr", S_D1, 1'b1);
        rn[S_D1] = 1'b1; ptclr[S_D1] = 1'b0;

        // 4: reset mid-toggle, INIT=1
        pt[S_T1] = 5'b00001; ce[S_T1] = 1'b1;
        tick(); check_q("mt_tog0", S_T1, 1'b0);
        tick(); check_q("mt_tog1", S_T1, 1'b1);
        tick(); check_q("mt_tog2", S_T1, 1'b0);
        rn[S_T1] = 1'b0;
        tick(); check_q("mt_rst", S_T1, 1'b1);
        rn[S_T1] = 1'b1;
        tick(); check_q("mt_resume0", S_T1, 1'b0);
        tick(); check_q("mt_resume1", S_T1, 1'b1);

        // 5: combinational bypass, inverted polarity
        pt[S_C] = 5'b00000;
        #1 check_q("c_pt0", S_C, 1'b1);
        pt[S_C] = 5'b01000;
        #1 check_q("c_pt3", S_C, 1'b0);
        rn[S_C] = 1'b0; ptclr[S_C] = 1'b1;
        tick(); check_q("c_rn_clr_ignored", S_C, 1'b0);
        pt[S_C] = 5'b00000;
        #1 check_q("c_follow_in_rst", S_C, 1'b1);
        ptclr[S_C] = 1'b0; ptset[S_C] = 1'b1; pt[S_C] = 5'b10000;
        tick(); check_q("c_set_ignored", S_C, 1'b0);
        rn[S_C] = 1'b1; ptset[S_C] = 1'b0;
        ptoe[S_C] = 1'b1;
        #1 check_bit("c_oe", oe[S_C], 1'b1);

        // 6: PT[0] as clock enable
        ce[S_P] = 1'b1; pt[S_P] = 5'b00010;
        tick(); check_q("p_hold", S_P, 1'b0);
        pt[S_P] = 5'b00011;
        tick(); check_q("p_load", S_P, 1'b1);
        pt[S_P] = 5'b00001;
        tick(); check_q("p_pt0_not_summed", S_P, 1'b0);
        ce[S_P] = 1'b0; pt[S_P] = 5'b00011;
        tick(); check_q("p_ce_low_hold", S_P, 1'b0);
        ptoe[S_P] = 1'b1;
        #1 check_bit("p_oe_hi", oe[S_P], 1'b1);
        ptoe[S_P] = 1'b0;
        #1 check_bit("p_oe_lo", oe[S_P], 1'b0);
        check_q("p_z0_with_oe_lo", S_P, 1'b0);
        ptoe[S_P] = 1'b1;
        #1 check_bit("p_oe_hi2", oe[S_P], 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
